// File: rtl/cnn_datapath_param.sv
// CNN datapath: shared source bus, core and general registers, a combinational ALU,
// a multi-cycle saturating fixed-point MAC and nested X/Y window counters.
module cnn_datapath_param #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 12,
    parameter int NUM_GPR = 8,
    parameter int IDX_W   = 8,
    parameter int FRAC_W  = 8,
    parameter int MAC_LAT = 3,
    parameter int ACC_W   = 2*DATA_W+8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ac_load,
    input  logic               dr_load,
    input  logic               tr_load,
    input  logic               ir_load,
    input  logic               pc_load,
    input  logic               ar_load,
    input  logic               pc_inc,
    input  logic               ar_inc,
    input  logic [NUM_GPR-1:0] gpr_load,
    input  logic [2:0]         alu_sel,
    input  logic [4:0]         bus_sel,
    input  logic               mac_start,
    input  logic               mac_clr,
    input  logic               cnt_clr,
    input  logic               cnt_step,
    input  logic [IDX_W-1:0]   x_limit,
    input  logic [IDX_W-1:0]   y_limit,
    input  logic               flag_en,
    input  logic [DATA_W-1:0]  compare_val,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  bus_value,
    output logic [DATA_W-1:0]  ac_value,
    output logic [DATA_W-1:0]  dr_value,
    output logic [DATA_W-1:0]  ir_value,
    output logic [ADDR_W-1:0]  pc_value,
    output logic [IDX_W-1:0]   x_idx,
    output logic [IDX_W-1:0]   y_idx,
    output logic               mac_busy,
    output logic               mac_done,
    output logic               mac_ovf,
    output logic               frame_done,
    output logic               zero,
    output logic               equal,
    output logic               neg
);

    localparam int CNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic signed [ACC_W-1:0] ACCQ_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACCQ_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {MAC_IDLE = 1'b0, MAC_BUSY = 1'b1} mac_state_t;

    logic [DATA_W-1:0]        r_ac, r_dr, r_tr, r_ir;
    logic [ADDR_W-1:0]        r_pc, r_ar;
    logic [DATA_W-1:0]        r_gpr [NUM_GPR];
    logic [IDX_W-1:0]         r_x, r_y;
    logic                     r_frame_done, r_zero, r_equal, r_neg;
    mac_state_t               r_mac_state, w_mac_state_nxt;
    logic [CNT_W-1:0]         r_mac_cnt;
    logic [DATA_W-1:0]        r_mac_a, r_mac_b;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_mac_done, r_mac_ovf;

    logic [DATA_W-1:0]        w_bus, w_alu, w_acc_q;
    logic signed [ACC_W-1:0]  w_acc_sh, w_acc_nxt;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W:0]    w_sum;
    logic                     w_sum_ovf, w_mac_accept, w_mac_finish;
    logic [IDX_W-1:0]         w_x_lim, w_y_lim;
    logic                     w_x_last, w_y_last;

    // ACC read-back: drop the fraction, then clamp into the signed bus range.
    assign w_acc_sh = r_acc >>> FRAC_W;
    always_comb begin
        if (w_acc_sh > ACCQ_MAX)      w_acc_q = ACCQ_MAX[DATA_W-1:0];
        else if (w_acc_sh < ACCQ_MIN) w_acc_q = ACCQ_MIN[DATA_W-1:0];
        else                          w_acc_q = w_acc_sh[DATA_W-1:0];
    end

    always_comb begin
        w_bus = '0;
        case (bus_sel)
            5'd0: w_bus = r_dr;
            5'd1: w_bus = r_ac;
            5'd2: w_bus = r_tr;
            5'd3: w_bus[ADDR_W-1:0] = r_pc;
            5'd4: w_bus = mem_rdata;
            5'd5: w_bus[IDX_W-1:0] = r_x;
            5'd6: w_bus[IDX_W-1:0] = r_y;
            5'd7: w_bus = w_acc_q;
            default: begin
                for (int i = 0; i < NUM_GPR; i++)
                    if (bus_sel == 5'(8 + i)) w_bus = r_gpr[i];
            end
        endcase
    end

    always_comb begin
        w_alu = r_dr;
        case (alu_sel)
            3'd1: w_alu = r_ac + r_dr;
            3'd2: w_alu = r_ac - r_dr;
            3'd3: w_alu = r_ac & r_dr;
            3'd4: w_alu = r_ac | r_dr;
            3'd5: w_alu = r_ac ^ r_dr;
            3'd6: w_alu = r_ac << 1;
            3'd7: w_alu = $signed(r_ac) >>> 1;
            default: w_alu = r_dr;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ac <= '0; r_dr <= '0; r_tr <= '0; r_ir <= '0;
            r_pc <= '0; r_ar <= '0;
            r_zero <= 1'b0; r_equal <= 1'b0; r_neg <= 1'b0;
        end else begin
            if (ac_load) r_ac <= w_alu;
            if (dr_load) r_dr <= w_bus;
            if (tr_load) r_tr <= w_bus;
            if (ir_load) r_ir <= w_bus;
            if (pc_load)     r_pc <= w_bus[ADDR_W-1:0];
            else if (pc_inc) r_pc <= r_pc + ADDR_W'(1);
            if (ar_load)     r_ar <= w_bus[ADDR_W-1:0];
            else if (ar_inc) r_ar <= r_ar + ADDR_W'(1);
            if (flag_en) begin
                r_zero  <= (w_bus == '0);
                r_equal <= (w_bus == compare_val);
                r_neg   <= w_bus[DATA_W-1];
            end
        end
    end

    // NOTE: the GPR bank is cleared by reset, so it must stay in flops rather than map to a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_GPR; i++) r_gpr[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_GPR; i++)
                if (gpr_load[i]) r_gpr[i] <= w_bus;
        end
    end

    // Window scan; a zero limit behaves as one, and an out-of-range index runs on until it wraps.
    assign w_x_lim  = (x_limit == '0) ? IDX_W'(1) : x_limit;
    assign w_y_lim  = (y_limit == '0) ? IDX_W'(1) : y_limit;
    assign w_x_last = (r_x == w_x_lim - IDX_W'(1));
    assign w_y_last = (r_y == w_y_lim - IDX_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0; r_y <= '0; r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (cnt_clr) begin
                r_x <= '0; r_y <= '0;
            end else if (cnt_step) begin
                if (w_x_last) begin
                    r_x <= '0;
                    if (w_y_last) begin
                        r_y <= '0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_y <= r_y + IDX_W'(1);
                    end
                end else begin
                    r_x <= r_x + IDX_W'(1);
                end
            end
        end
    end

    // MAC control: a start in IDLE is always accepted, even alongside mac_clr.
    always_comb begin
        w_mac_state_nxt = r_mac_state;
        w_mac_accept    = 1'b0;
        w_mac_finish    = 1'b0;
        case (r_mac_state)
            MAC_IDLE: if (mac_start) begin
                w_mac_accept    = 1'b1;
                w_mac_state_nxt = MAC_BUSY;
            end
            MAC_BUSY: if (mac_clr) begin
                w_mac_state_nxt = MAC_IDLE;
            end else if (r_mac_cnt == '0) begin
                w_mac_finish    = 1'b1;
                w_mac_state_nxt = MAC_IDLE;
            end
            default: w_mac_state_nxt = MAC_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_mac_state <= MAC_IDLE;
        else     r_mac_state <= w_mac_state_nxt;
    end

    assign w_prod    = $signed(r_mac_a) * $signed(r_mac_b);
    assign w_sum     = {r_acc[ACC_W-1], r_acc} + {{(ACC_W+1-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    assign w_sum_ovf = (w_sum[ACC_W] != w_sum[ACC_W-1]);
    assign w_acc_nxt = !w_sum_ovf ? w_sum[ACC_W-1:0] : (w_sum[ACC_W] ? ACC_MIN : ACC_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mac_cnt <= '0; r_mac_a <= '0; r_mac_b <= '0;
            r_acc <= '0; r_mac_done <= 1'b0; r_mac_ovf <= 1'b0;
        end else begin
            r_mac_done <= w_mac_finish;
            if (w_mac_accept) begin
                r_mac_a   <= r_ac;
                r_mac_b   <= r_dr;
                r_mac_cnt <= CNT_W'(MAC_LAT - 1);
            end else if (r_mac_state == MAC_BUSY && r_mac_cnt != '0) begin
                r_mac_cnt <= r_mac_cnt - CNT_W'(1);
            end
            if (mac_clr) begin
                r_acc     <= '0;
                r_mac_ovf <= 1'b0;
            end else if (w_mac_finish) begin
                r_acc <= w_acc_nxt;
                if (w_sum_ovf) r_mac_ovf <= 1'b1;
            end
        end
    end

    assign mem_wdata  = w_bus;
    assign mem_addr   = r_ar;
    assign bus_value  = w_bus;
    assign ac_value   = r_ac;
    assign dr_value   = r_dr;
    assign ir_value   = r_ir;
    assign pc_value   = r_pc;
    assign x_idx      = r_x;
    assign y_idx      = r_y;
    assign mac_busy   = (r_mac_state == MAC_BUSY);
    assign mac_done   = r_mac_done;
    assign mac_ovf    = r_mac_ovf;
    assign frame_done = r_frame_done;
    assign zero       = r_zero;
    assign equal      = r_equal;
    assign neg        = r_neg;

endmodule

// File: tb/tb_cnn_datapath_param.sv
// Directed bench for cnn_datapath_param: reset, ALU, MAC timing/saturation, window counters,
// GPR/flags and PC/AR behaviour, each checked against hand-computed values.
module tb_cnn_datapath_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        ac_load, dr_load, tr_load, ir_load, pc_load, ar_load, pc_inc, ar_inc;
    logic [7:0]  gpr_load;
    logic [2:0]  alu_sel;
    logic [4:0]  bus_sel;
    logic        mac_start, mac_clr, cnt_clr, cnt_step, flag_en;
    logic [7:0]  x_limit, y_limit;
    logic [15:0] compare_val, mem_rdata;
    logic [15:0] mem_wdata, bus_value, ac_value, dr_value, ir_value;
    logic [11:0] mem_addr, pc_value;
    logic [7:0]  x_idx, y_idx;
    logic        mac_busy, mac_done, mac_ovf, frame_done, zero, equal, neg;

    int n_checks = 0;
    int n_fail   = 0;

    cnn_datapath_param dut (
        .clk(clk), .rst(rst),
        .ac_load(ac_load), .dr_load(dr_load), .tr_load(tr_load), .ir_load(ir_load),
        .pc_load(pc_load), .ar_load(ar_load), .pc_inc(pc_inc), .ar_inc(ar_inc),
        .gpr_load(gpr_load), .alu_sel(alu_sel), .bus_sel(bus_sel),
        .mac_start(mac_start), .mac_clr(mac_clr), .cnt_clr(cnt_clr), .cnt_step(cnt_step),
        .x_limit(x_limit), .y_limit(y_limit), .flag_en(flag_en),
        .compare_val(compare_val), .mem_rdata(mem_rdata),
        .mem_wdata(mem_wdata), .mem_addr(mem_addr), .bus_value(bus_value),
        .ac_value(ac_value), .dr_value(dr_value), .ir_value(ir_value), .pc_value(pc_value),
        .x_idx(x_idx), .y_idx(y_idx),
        .mac_busy(mac_busy), .mac_done(mac_done), .mac_ovf(mac_ovf),
        .frame_done(frame_done), .zero(zero), .equal(equal), .neg(neg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ac_dr(input logic [15:0] a, input logic [15:0] b);
        bus_sel = 5'd4; mem_rdata = a; dr_load = 1'b1;
        tick();
        dr_load = 1'b0; alu_sel = 3'd0; ac_load = 1'b1;
        tick();
        ac_load = 1'b0; mem_rdata = b; dr_load = 1'b1;
        tick();
        dr_load = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            tick();
            if (mac_done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            $display("FAIL %s: mac_done not seen within 12 cycles", name);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        bus_sel = 5'd7;
        #1;
        n_checks++;
        if ({ac_value, dr_value, ir_value, bus_value} !== 64'h0) begin
            $display("FAIL reset_regs: got %h/%h/%h/%h required all 0", ac_value, dr_value, ir_value, bus_value);
            n_fail++;
        end
        n_checks++;
        if ({pc_value, mem_addr, x_idx, y_idx} !== 40'h0) begin
            $display("FAIL reset_ptrs: got pc=%h ar=%h x=%h y=%h required 0", pc_value, mem_addr, x_idx, y_idx);
            n_fail++;
        end
        n_checks++;
        if ({mac_busy, mac_done, mac_ovf, frame_done, zero, equal, neg} !== 7'b0) begin
            $display("FAIL reset_status: got %b required 0000000",
                     {mac_busy, mac_done, mac_ovf, frame_done, zero, equal, neg});
            n_fail++;
        end
        // Asynchronous reset in the middle of a MAC operation.
        load_ac_dr(16'h0200, 16'h0180);
        mac_start = 1'b1;
        tick();
        mac_start = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        bus_sel = 5'd1;
        #1;
        n_checks++;
        if ({mac_busy, ac_value, dr_value, bus_value} !== 49'h0) begin
            $display("FAIL reset_async: got busy=%b ac=%h dr=%h bus=%h required all 0",
                     mac_busy, ac_value, dr_value, bus_value);
            n_fail++;
        end
        tick();
        rst = 1'b0;
        begin
            bit done_seen = 1'b0;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (mac_done !== 1'b0) done_seen = 1'b1;
            end
            n_checks++;
            if (done_seen) begin
                $display("FAIL reset_no_done: got mac_done after reset required none");
                n_fail++;
            end
        end
    endtask

    task automatic test_alu();
        load_ac_dr(16'h1234, 16'h0F0F);
        alu_sel = 3'd1; ac_load = 1'b1;
        tick();
        n_checks++;
        if (ac_value !== 16'h2143) begin
            $display("FAIL alu_add: got %h required 2143", ac_value); n_fail++;
        end
        alu_sel = 3'd5;
        tick();
        n_checks++;
        if (ac_value !== 16'h2E4C) begin
            $display("FAIL alu_xor: got %h required 2E4C", ac_value); n_fail++;
        end
        alu_sel = 3'd6;
        tick();
        ac_load = 1'b0;
        n_checks++;
        if (ac_value !== 16'h5C98) begin
            $display("FAIL alu_shl: got %h required 5C98", ac_value); n_fail++;
        end
    endtask

    task automatic test_mac_basic();
        logic [2:0] busy_seq, done_seq;
        load_ac_dr(16'h0200, 16'h0180);
        mac_start = 1'b1;
        tick();
        mac_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            busy_seq[k] = mac_busy;
            done_seq[k] = mac_done;
            tick();
        end
        n_checks++;
        if (busy_seq !== 3'b111 || done_seq !== 3'b000 || mac_busy !== 1'b0 || mac_done !== 1'b1) begin
            $display("FAIL mac_timing: got busy=%b done=%b then busy=%b done=%b required 111/000 then 0/1",
                     busy_seq, done_seq, mac_busy, mac_done);
            n_fail++;
        end
        bus_sel = 5'd7;
        tick();
        n_checks++;
        if (mac_done !== 1'b0 || bus_value !== 16'h0300) begin
            $display("FAIL mac_first: got done=%b accq=%h required 0/0300", mac_done, bus_value);
            n_fail++;
        end
        mac_start = 1'b1;
        tick();
        mac_start = 1'b0;
        wait_done("mac_second_wait");
        #1;
        n_checks++;
        if (bus_value !== 16'h0600) begin
            $display("FAIL mac_second: got %h required 0600", bus_value); n_fail++;
        end
        mac_clr = 1'b1;
        tick();
        mac_clr = 1'b0;
        n_checks++;
        if (bus_value !== 16'h0000) begin
            $display("FAIL mac_clear: got %h required 0000", bus_value); n_fail++;
        end
    endtask

    task automatic test_mac_sat();
        load_ac_dr(16'h7FFF, 16'h7FFF);
        mac_start = 1'b1;
        tick();
        mac_start = 1'b0;
        wait_done("sat_pos_wait");
        bus_sel = 5'd7;
        #1;
        n_checks++;
        if (bus_value !== 16'h7FFF) begin
            $display("FAIL sat_pos: got %h required 7FFF", bus_value); n_fail++;
        end
        mac_clr = 1'b1;
        tick();
        mac_clr = 1'b0;
        load_ac_dr(16'h8000, 16'h7FFF);
        mac_start = 1'b1;
        tick();
        mac_start = 1'b0;
        wait_done("sat_neg_wait");
        bus_sel = 5'd7;
        #1;
        n_checks++;
        if (bus_value !== 16'h8000 || mac_ovf !== 1'b0) begin
            $display("FAIL sat_neg: got accq=%h ovf=%b required 8000/0", bus_value, mac_ovf);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        mac_clr = 1'b1;
        tick();
        mac_clr = 1'b0;
        load_ac_dr(16'h0100, 16'h0100);
        mac_start = 1'b1;
        tick();
        mac_start = 1'b0;
        wait_done("b2b_first_wait");
        mac_start = 1'b1;
        tick();
        mac_start = 1'b0;
        n_checks++;
        if (mac_busy !== 1'b1) begin
            $display("FAIL b2b_accept: got busy=%b required 1", mac_busy); n_fail++;
        end
        mac_start = 1'b1;
        tick();
        mac_start = 1'b0;
        wait_done("b2b_second_wait");
        bus_sel = 5'd7;
        tick();
        n_checks++;
        if (mac_busy !== 1'b0 || bus_value !== 16'h0200) begin
            $display("FAIL b2b_result: got busy=%b accq=%h required 0/0200", mac_busy, bus_value);
            n_fail++;
        end
        // mac_clr while busy aborts: no done, accumulator cleared.
        mac_start = 1'b1;
        tick();
        mac_start = 1'b0;
        mac_clr = 1'b1;
        tick();
        mac_clr = 1'b0;
        begin
            bit done_seen = 1'b0;
            for (int k = 0; k < 5; k++) begin
                if (mac_done !== 1'b0) done_seen = 1'b1;
                tick();
            end
            n_checks++;
            if (done_seen || mac_busy !== 1'b0 || bus_value !== 16'h0000) begin
                $display("FAIL mac_abort: got done_seen=%b busy=%b accq=%h required 0/0/0000",
                         done_seen, mac_busy, bus_value);
                n_fail++;
            end
        end
    endtask

    task automatic test_counters();
        logic [16:0] exp_tab [6];
        exp_tab[0] = {8'd1, 8'd0, 1'b0};
        exp_tab[1] = {8'd2, 8'd0, 1'b0};
        exp_tab[2] = {8'd0, 8'd1, 1'b0};
        exp_tab[3] = {8'd1, 8'd1, 1'b0};
        exp_tab[4] = {8'd2, 8'd1, 1'b0};
        exp_tab[5] = {8'd0, 8'd0, 1'b1};
        x_limit = 8'd3; y_limit = 8'd2;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        cnt_step = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++;
            if ({x_idx, y_idx, frame_done} !== exp_tab[k]) begin
                $display("FAIL cnt_step%0d: got x=%0d y=%0d fd=%b required x=%0d y=%0d fd=%b",
                         k + 1, x_idx, y_idx, frame_done, exp_tab[k][16:9], exp_tab[k][8:1], exp_tab[k][0]);
                n_fail++;
            end
        end
        cnt_step = 1'b0;
        tick();
        n_checks++;
        if (frame_done !== 1'b0) begin
            $display("FAIL cnt_fd_pulse: got %b required 0", frame_done); n_fail++;
        end
        x_limit = 8'd0;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        cnt_step = 1'b1;
        tick();
        n_checks++;
        if ({x_idx, y_idx, frame_done} !== {8'd0, 8'd1, 1'b0}) begin
            $display("FAIL cnt_xlim0_a: got x=%0d y=%0d fd=%b required 0/1/0", x_idx, y_idx, frame_done);
            n_fail++;
        end
        tick();
        cnt_step = 1'b0;
        n_checks++;
        if ({x_idx, y_idx, frame_done} !== {8'd0, 8'd0, 1'b1}) begin
            $display("FAIL cnt_xlim0_b: got x=%0d y=%0d fd=%b required 0/0/1", x_idx, y_idx, frame_done);
            n_fail++;
        end
    endtask

    task automatic test_gpr_flags();
        bus_sel = 5'd4; mem_rdata = 16'hBEEF; gpr_load = 8'b0000_0100;
        tick();
        gpr_load = 8'b0;
        bus_sel = 5'd10; compare_val = 16'hBEEF; flag_en = 1'b1;
        #1;
        n_checks++;
        if (bus_value !== 16'hBEEF || mem_wdata !== 16'hBEEF) begin
            $display("FAIL gpr_read: got bus=%h wdata=%h required BEEF", bus_value, mem_wdata); n_fail++;
        end
        tick();
        flag_en = 1'b0;
        n_checks++;
        if ({zero, equal, neg} !== 3'b011) begin
            $display("FAIL flags: got zero/equal/neg=%b required 011", {zero, equal, neg}); n_fail++;
        end
        bus_sel = 5'd9;
        #1;
        n_checks++;
        if (bus_value !== 16'h0000) begin
            $display("FAIL gpr_other: got %h required 0000", bus_value); n_fail++;
        end
    endtask

    task automatic test_pc_ar();
        bus_sel = 5'd4; mem_rdata = 16'h0FFF; pc_load = 1'b1;
        tick();
        pc_load = 1'b0;
        n_checks++;
        if (pc_value !== 12'hFFF) begin
            $display("FAIL pc_load: got %h required FFF", pc_value); n_fail++;
        end
        pc_inc = 1'b1;
        tick();
        pc_inc = 1'b0;
        n_checks++;
        if (pc_value !== 12'h000) begin
            $display("FAIL pc_wrap: got %h required 000", pc_value); n_fail++;
        end
        mem_rdata = 16'h0123; pc_load = 1'b1; pc_inc = 1'b1;
        tick();
        pc_load = 1'b0; pc_inc = 1'b0;
        n_checks++;
        if (pc_value !== 12'h123) begin
            $display("FAIL pc_load_beats_inc: got %h required 123", pc_value); n_fail++;
        end
        mem_rdata = 16'hFABC; ar_load = 1'b1;
        tick();
        ar_load = 1'b0; ar_inc = 1'b1;
        tick();
        ar_inc = 1'b0;
        n_checks++;
        if (mem_addr !== 12'hABD) begin
            $display("FAIL ar_load_inc: got %h required ABD", mem_addr); n_fail++;
        end
        bus_sel = 5'd3;
        #1;
        n_checks++;
        if (bus_value !== 16'h0123) begin
            $display("FAIL bus_pc: got %h required 0123", bus_value); n_fail++;
        end
        bus_sel = 5'd20;
        #1;
        n_checks++;
        if (bus_value !== 16'h0000) begin
            $display("FAIL bus_unused: got %h required 0000", bus_value); n_fail++;
        end
    endtask

    initial begin
        rst = 1'b1;
        {ac_load, dr_load, tr_load, ir_load, pc_load, ar_load, pc_inc, ar_inc} = '0;
        gpr_load = '0; alu_sel = '0; bus_sel = '0;
        {mac_start, mac_clr, cnt_clr, cnt_step, flag_en} = '0;
        x_limit = '0; y_limit = '0; compare_val = '0; mem_rdata = '0;
        test_reset();
        test_alu();
        test_mac_basic();
        test_mac_sat();
        test_back_to_back();
        test_counters();
        test_gpr_flags();
        test_pc_ar();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cnn_datapath_param.md
Name: cnn_datapath_param

Overview:
Parametrised next-generation CNN datapath: shared source bus, core registers (AC, DR, TR, IR, PC, AR), a bank of NUM_GPR general registers (feature/kernel/partial-sum storage), and a combinational ALU. Adds two blocks the 16-bit datapath lacks: a multi-cycle signed fixed-point MAC with start/busy/done handshake, and nested X/Y window counters with wrap and frame-done. Driven by the CNN control unit; AR addresses external memory.

Parameters:
DATA_W, 16, data/bus width
ADDR_W, 12, PC/AR/memory address width (<= DATA_W)
NUM_GPR, 8, general registers (1..16)
IDX_W, 8, X/Y counter width (<= DATA_W)
FRAC_W, 8, fractional bits of fixed-point operands
MAC_LAT, 3, cycles from accepted mac_start to mac_done (>= 1)
ACC_W, 2*DATA_W+8, accumulator width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
ac_load, dr_load, tr_load, ir_load, pc_load, ar_load  in  1 each  load from bus (AC loads ALU result)
pc_inc, ar_inc  in  1 each  increment
gpr_load  in  NUM_GPR  per-register load from bus; multiple bits allowed
alu_sel  in  3  ALU op
bus_sel  in  5  bus source
mac_start, mac_clr  in  1 each  MAC control
cnt_clr, cnt_step  in  1 each  window counter control
x_limit, y_limit  in  IDX_W each  counter limits
flag_en  in  1  capture flags
compare_val  in  DATA_W  equality reference
mem_rdata  in  DATA_W  memory read data
mem_wdata  out  DATA_W  = bus
mem_addr  out  ADDR_W  = AR
bus_value  out  DATA_W  current bus
ac_value, dr_value, ir_value  out  DATA_W  register taps
pc_value  out  ADDR_W  PC tap
x_idx, y_idx  out  IDX_W  counter values
mac_busy, mac_done, mac_ovf  out  1 each  MAC status
frame_done  out  1  one-cycle pulse at window-scan end
zero, equal, neg  out  1 each  registered flags

Behaviour:
- Reset (async): all registers, GPRs, ACC, counters, flags, mac_busy/done/ovf, frame_done = 0, effective immediately, incl. mid-MAC (operation dropped, no done).
- Bus: 0 DR, 1 AC, 2 TR, 3 PC zero-ext, 4 mem_rdata, 5 X zero-ext, 6 Y zero-ext, 7 ACC_Q, 8..8+NUM_GPR-1 GPR[i], 31 and all unused codes = 0.
- ACC_Q = ACC arithmetic-shifted right FRAC_W, saturated to signed DATA_W (max 0x7FFF / min 0x8000 at 16 bit).
- ALU (a=AC, b=DR): 0 pass b, 1 a+b, 2 a-b, 3 and, 4 or, 5 xor, 6 a<<1, 7 a>>>1; result truncated to DATA_W.
- PC/AR: load beats inc; load takes bus[ADDR_W-1:0]; inc wraps all-ones -> 0.
- Flags when flag_en: zero=(bus==0), equal=(bus==compare_val), neg=bus[DATA_W-1]; else hold.
- MAC states IDLE/BUSY. IDLE + mac_start: capture AC, DR; busy=1. mac_done pulses 1 cycle exactly MAC_LAT cycles after the start edge, same edge ACC <= sat_ACC_W(ACC + AC*DR signed), busy=0. mac_start while busy ignored. Back-to-back: start in the done cycle accepted. Saturation sets sticky mac_ovf.
- mac_clr: ACC=0, mac_ovf=0; if busy, abort (busy=0, no done). mac_clr+mac_start while idle: clear, then operation accepted (adds to 0).
- Counters: limit 0 treated as 1. cnt_clr (priority) zeroes X,Y. cnt_step: X+1; at X==x_limit-1, X=0 and Y+1; if also Y==y_limit-1, Y=0 and frame_done pulses that cycle. Limit changes mid-scan take effect at next comparison; X>=limit compares equal-only, wraps at counter overflow.

Test Plan:
- Assert rst 2 cycles after mac_start (AC=0x0200, DR=0x0180) -> immediately all outputs 0, mac_busy=0, no mac_done afterwards.
- AC=0x0200, DR=0x0180, mac_start -> mac_busy 3 cycles, mac_done at cycle 3, bus_sel=7 gives 0x0300; second start -> 0x0600; mac_clr -> 0x0000.
- AC=0x7FFF, DR=0x7FFF, MAC -> ACC_Q 0x7FFF; after mac_clr, AC=0x8000, DR=0x7FFF -> ACC_Q 0x8000; mac_ovf stays 0.
- x_limit=3, y_limit=2, cnt_clr then 6 cnt_step -> (X,Y) 1,0 2,0 0,1 1,1 2,1 0,0; frame_done only on 6th step; x_limit=0 -> every step bumps Y.
- bus_sel=4, mem_rdata=0xBEEF, gpr_load=0b00000100; then bus_sel=10, flag_en, compare_val=0xBEEF -> bus 0xBEEF, equal=1, neg=1, zero=0.
- PC=0xFFF, pc_inc -> 0x000; pc_load+pc_inc with bus=0x0123 -> PC=0x123; bus_sel=20 -> bus 0x0000.
